// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA timing generator:
//   - default 640x480@60 timing constants (25 MHz pixel clock)
//   - counter width used by both axes
//   - phase encoding shared by the horizontal and vertical decoders
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int TOTAL_COLS  = 800;
    localparam int TOTAL_ROWS  = 525;
    localparam int ACTIVE_COLS = 640;
    localparam int ACTIVE_ROWS = 480;
    localparam int H_FRONT     = 16;
    localparam int H_SYNC      = 96;
    localparam int V_FRONT     = 10;
    localparam int V_SYNC      = 2;

    localparam int FRAMES_PER_TICK = 6;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One timing axis: a wrapping position counter plus a phase FSM
// (ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE) that tracks which region the
// current count lies in. Used once per line (horizontal) and once per frame
// (vertical, stepped by the horizontal wrap).
//
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset (count 0, phase ACTIVE)
//   en     in   advance one position this clock
//   count  out  current position, 0..c_TOTAL-1
//   phase  out  region of the current position
//   wrap   out  high while enabled at the last position (next step wraps)
// -----------------------------------------------------------------------------
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int c_TOTAL  = TOTAL_COLS,
    parameter int c_ACTIVE = ACTIVE_COLS,
    parameter int c_FRONT  = H_FRONT,
    parameter int c_SYNC   = H_SYNC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output phase_t           phase,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST        = CNT_W'(c_TOTAL - 1);
    localparam logic [CNT_W-1:0] FRONT_START = CNT_W'(c_ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_START  = CNT_W'(c_ACTIVE + c_FRONT);
    localparam logic [CNT_W-1:0] BACK_START  = CNT_W'(c_ACTIVE + c_FRONT + c_SYNC);

    logic [CNT_W-1:0] count_next;

    assign wrap       = en && (count == LAST);
    assign count_next = (count == LAST) ? '0 : count + 1'b1;

    // The phase changes on the same edge the count crosses a boundary, so
    // phase always describes the count it is registered alongside.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            phase <= PH_ACTIVE;
        end else if (en) begin
            count <= count_next;
            case (phase)
                PH_ACTIVE: if (count_next == FRONT_START) phase <= PH_FRONT;
                PH_FRONT:  if (count_next == SYNC_START)  phase <= PH_SYNC;
                PH_SYNC:   if (count_next == BACK_START)  phase <= PH_BACK;
                PH_BACK:   if (count_next == '0)          phase <= PH_ACTIVE;
                default:                                  phase <= PH_ACTIVE;
            endcase
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
// Free-running VGA timing generator. Internal column/row counters walk the
// frame; every output is registered one clock behind them so that counts,
// syncs, active flag and pulses all describe the same pixel.
//
// Optional feature: define VGA_GAME_TICK_EN to build a frame counter that
// pulses o_Game_Tick with every c_FRAMES_PER_TICK-th o_Frame_Start.
// Without it o_Game_Tick is tied low.
//
// Ports:
//   i_Clk          in   pixel clock
//   i_Rst          in   asynchronous active-high reset
//   i_Enable       in   count enable; low freezes timing, pulses forced 0
//   o_HSync        out  horizontal sync, active-low
//   o_VSync        out  vertical sync, active-low (whole lines)
//   o_Col_Count    out  current column
//   o_Row_Count    out  current row
//   o_Active       out  visible-area flag
//   o_Frame_Start  out  one-cycle pulse at col 0, row 0
//   o_Game_Tick    out  one-cycle pulse every c_FRAMES_PER_TICK frames
// -----------------------------------------------------------------------------
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int c_TOTAL_COLS      = TOTAL_COLS,
    parameter int c_TOTAL_ROWS      = TOTAL_ROWS,
    parameter int c_ACTIVE_COLS     = ACTIVE_COLS,
    parameter int c_ACTIVE_ROWS     = ACTIVE_ROWS,
    parameter int c_H_FRONT         = H_FRONT,
    parameter int c_H_SYNC          = H_SYNC,
    parameter int c_V_FRONT         = V_FRONT,
    parameter int c_V_SYNC          = V_SYNC,
    parameter int c_FRAMES_PER_TICK = FRAMES_PER_TICK
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Enable,
    output logic             o_HSync,
    output logic             o_VSync,
    output logic [CNT_W-1:0] o_Col_Count,
    output logic [CNT_W-1:0] o_Row_Count,
    output logic             o_Active,
    output logic             o_Frame_Start,
    output logic             o_Game_Tick
);

    // Reject timings the 10-bit counters or the phase decode cannot express.
    if (c_ACTIVE_COLS + c_H_FRONT + c_H_SYNC >= c_TOTAL_COLS ||
        c_ACTIVE_ROWS + c_V_FRONT + c_V_SYNC >= c_TOTAL_ROWS ||
        c_TOTAL_COLS > (1 << CNT_W) || c_TOTAL_ROWS > (1 << CNT_W) ||
        c_FRAMES_PER_TICK < 1) begin : g_bad_params
        $error("vga_sync_gen: invalid timing parameters");
    end

    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    phase_t           h_phase;
    phase_t           v_phase;
    logic             h_wrap;
    logic             v_wrap;
    logic             at_origin;

    vga_axis_counter #(
        .c_TOTAL  (c_TOTAL_COLS),
        .c_ACTIVE (c_ACTIVE_COLS),
        .c_FRONT  (c_H_FRONT),
        .c_SYNC   (c_H_SYNC)
    ) u_h_axis (
        .clk   (i_Clk),
        .rst   (i_Rst),
        .en    (i_Enable),
        .count (h_count),
        .phase (h_phase),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(
        .c_TOTAL  (c_TOTAL_ROWS),
        .c_ACTIVE (c_ACTIVE_ROWS),
        .c_FRONT  (c_V_FRONT),
        .c_SYNC   (c_V_SYNC)
    ) u_v_axis (
        .clk   (i_Clk),
        .rst   (i_Rst),
        .en    (h_wrap),
        .count (v_count),
        .phase (v_phase),
        .wrap  (v_wrap)
    );

    // Flag that the counters sit at (0,0): set by the end-of-frame wrap,
    // cleared by any other step. Avoids a 20-bit compare on both counts.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            at_origin <= 1'b1;
        end else if (i_Enable) begin
            at_origin <= v_wrap;
        end
    end

    // Output stage: one clock behind the counters; held while disabled,
    // except the pulses, which must not repeat while frozen.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            o_HSync       <= 1'b1;
            o_VSync       <= 1'b1;
            o_Col_Count   <= '0;
            o_Row_Count   <= '0;
            o_Active      <= 1'b0;
            o_Frame_Start <= 1'b0;
        end else if (i_Enable) begin
            o_HSync       <= (h_phase != PH_SYNC);
            o_VSync       <= (v_phase != PH_SYNC);
            o_Col_Count   <= h_count;
            o_Row_Count   <= v_count;
            o_Active      <= (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
            o_Frame_Start <= at_origin;
        end else begin
            o_Frame_Start <= 1'b0;
        end
    end

`ifdef VGA_GAME_TICK_EN
    localparam int TICK_W = (c_FRAMES_PER_TICK > 1) ? $clog2(c_FRAMES_PER_TICK) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(c_FRAMES_PER_TICK - 1);

    logic [TICK_W-1:0] frame_cnt;

    // Counts frame starts; the tick is registered with the same frame-start
    // condition so it coincides with the wrapping o_Frame_Start.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            frame_cnt   <= '0;
            o_Game_Tick <= 1'b0;
        end else begin
            o_Game_Tick <= 1'b0;
            if (i_Enable && at_origin) begin
                if (frame_cnt == TICK_LAST) begin
                    frame_cnt   <= '0;
                    o_Game_Tick <= 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end
`else
    assign o_Game_Tick = 1'b0;
`endif

endmodule
